// File: rtl/mem_bus_arbiter_pkg.sv
// Shared core types used by the memory-side blocks: LSU operation encodings
// and the owner tag that travels with every bus transaction.
package mem_bus_arbiter_pkg;

  typedef enum logic {
    LSU_LOAD  = 1'b0,
    LSU_STORE = 1'b1
  } lsu_op_e;

  typedef enum logic [1:0] {
    LSU_BYTE = 2'd0,
    LSU_HALF = 2'd1,
    LSU_WORD = 2'd2
  } lsu_dtype_e;

  // Which requester owns a bus transaction.
  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } bus_owner_e;

  // Fetches are always full-word reads.
  localparam logic [3:0] FETCH_BE = 4'hF;

endpackage

// File: rtl/mem_bus_arbiter_rsp_id_fifo.sv
// In-order FIFO of transaction owners: one entry is pushed per bus grant and
// popped per bus response, so the head always names the owner of the next
// response.
module rsp_id_fifo
  import mem_bus_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push_i,
  input  bus_owner_e                 push_owner_i,
  input  logic                       pop_i,
  output bus_owner_e                 head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  bus_owner_e       mem_q [DEPTH];

  logic do_push;
  logic do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Next-state for pointers and occupancy.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage.
  // NOTE: storage is deliberately not reset; an entry is only read after it was written, guarded by count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_owner_i;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between the fetch port and the LSU data port.
// Round-robin selection, held stable until the bus grants, with an owner FIFO
// that routes in-order responses back to whichever port issued them.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int DATA_FIRST_RST  = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic        instr_gnt,
  output logic        instr_valid,
  output logic [31:0] instr_rdata,
  output logic        instr_error,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_be,
  output logic        data_gnt,
  output logic        data_valid,
  output logic [31:0] data_rdata,
  output logic        data_error,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_gnt,
  input  logic        bus_valid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_error,
  output logic        spurious_rsp
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  // rr_ptr holds the last winner, so resetting it to the instr port lets data win first.
  localparam bus_owner_e RR_RST = (DATA_FIRST_RST != 0) ? OWN_INSTR : OWN_DATA;

  bus_owner_e rr_ptr_q, rr_ptr_d;
  logic       lock_valid_q, lock_valid_d;
  bus_owner_e lock_owner_q, lock_owner_d;

  bus_owner_e sel;
  logic       sel_req;
  logic       grant;
  logic       pop;

  bus_owner_e       fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // Requester selection: locked owner first, then the lone requester, then round-robin.
  always_comb begin
    sel = OWN_DATA;
    if (lock_valid_q) begin
      sel = lock_owner_q;
    end else if (instr_req && !data_req) begin
      sel = OWN_INSTR;
    end else if (data_req && !instr_req) begin
      sel = OWN_DATA;
    end else if (instr_req && data_req) begin
      sel = (rr_ptr_q == OWN_INSTR) ? OWN_DATA : OWN_INSTR;
    end
  end

  assign sel_req = (sel == OWN_INSTR) ? instr_req : data_req;
  assign bus_req = sel_req & ~fifo_full;
  assign grant   = bus_req & bus_gnt;

  assign instr_gnt = grant & (sel == OWN_INSTR);
  assign data_gnt  = grant & (sel == OWN_DATA);

  // Payload mux; when idle the data port's payload is passed through.
  assign bus_addr  = (sel == OWN_INSTR) ? instr_addr : data_addr;
  assign bus_wr    = (sel == OWN_INSTR) ? 1'b0       : data_wr;
  assign bus_wdata = (sel == OWN_INSTR) ? 32'h0      : data_wdata;
  assign bus_be    = (sel == OWN_INSTR) ? FETCH_BE   : data_be;

  // Response routing: the FIFO head names the owner of the arriving response.
  assign pop          = bus_valid & (fifo_count != '0);
  assign spurious_rsp = bus_valid & fifo_empty;
  assign instr_valid  = pop & (fifo_head == OWN_INSTR);
  assign data_valid   = pop & (fifo_head == OWN_DATA);
  assign instr_rdata  = instr_valid ? bus_rdata : 32'h0;
  assign instr_error  = instr_valid & bus_error;
  assign data_rdata   = data_valid ? bus_rdata : 32'h0;
  assign data_error   = data_valid & bus_error;

  // Lock and round-robin next-state.
  always_comb begin
    lock_valid_d = lock_valid_q;
    lock_owner_d = lock_owner_q;
    rr_ptr_d     = rr_ptr_q;
    if (grant) begin
      lock_valid_d = 1'b0;
      rr_ptr_d     = sel;
    end else if (bus_req) begin
      lock_valid_d = 1'b1;
      lock_owner_d = sel;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q     <= RR_RST;
      lock_valid_q <= 1'b0;
      lock_owner_q <= OWN_INSTR;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
    end
  end

  rsp_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_rsp_id_fifo (
    .clk          (clk),
    .reset_n      (reset_n),
    .push_i       (grant),
    .push_owner_i (sel),
    .pop_i        (pop),
    .head_o       (fifo_head),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .count_o      (fifo_count)
  );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: a table of single-cycle vectors
// from the reset state, then hand-written multi-cycle sequences with a
// response scoreboard.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt, instr_valid, instr_error;
  logic [31:0] instr_rdata;
  logic        data_req, data_wr;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_be;
  logic        data_gnt, data_valid, data_error;
  logic [31:0] data_rdata;
  logic        bus_req, bus_wr;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt, bus_valid, bus_error;
  logic [31:0] bus_rdata;
  logic        spurious_rsp;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bus_owner_e  owner;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;
  rsp_t sb_q[$];

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwr;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dbe;
    logic        bgnt;
    logic        bvalid;
    logic        e_breq;
    logic        e_bwr;
    logic [31:0] e_baddr;
    logic [31:0] e_bwdata;
    logic [3:0]  e_bbe;
    logic        e_igt;
    logic        e_dgt;
    logic        e_spur;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .MAX_OUTSTANDING (2),
    .DATA_FIRST_RST  (1)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .instr_req    (instr_req),
    .instr_addr   (instr_addr),
    .instr_gnt    (instr_gnt),
    .instr_valid  (instr_valid),
    .instr_rdata  (instr_rdata),
    .instr_error  (instr_error),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_be      (data_be),
    .data_gnt     (data_gnt),
    .data_valid   (data_valid),
    .data_rdata   (data_rdata),
    .data_error   (data_error),
    .bus_req      (bus_req),
    .bus_wr       (bus_wr),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_be       (bus_be),
    .bus_gnt      (bus_gnt),
    .bus_valid    (bus_valid),
    .bus_rdata    (bus_rdata),
    .bus_error    (bus_error),
    .spurious_rsp (spurious_rsp)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    instr_req  = 1'b0;
    instr_addr = 32'h0;
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_addr  = 32'h0;
    data_wdata = 32'h0;
    data_be    = 4'h0;
    bus_gnt    = 1'b0;
    bus_valid  = 1'b0;
    bus_rdata  = 32'h0;
    bus_error  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  // Check a grant the bench expects and queue the response it will later send.
  task automatic expect_grant(input bus_owner_e owner, input logic [31:0] rdata, input logic err);
    rsp_t r;
    check("instr_gnt", {31'b0, instr_gnt}, {31'b0, owner == OWN_INSTR});
    check("data_gnt",  {31'b0, data_gnt},  {31'b0, owner == OWN_DATA});
    r.owner = owner;
    r.rdata = rdata;
    r.err   = err;
    sb_q.push_back(r);
  endtask

  // Drive the oldest queued response and check it lands on the right port.
  task automatic respond();
    rsp_t r;
    if (sb_q.size() == 0) begin
      check("scoreboard_nonempty", 32'd0, 32'd1);
      return;
    end
    r = sb_q.pop_front();
    bus_valid = 1'b1;
    bus_rdata = r.rdata;
    bus_error = r.err;
    #1;
    if (r.owner == OWN_INSTR) begin
      check("instr_valid", {31'b0, instr_valid}, 32'd1);
      check("instr_rdata", instr_rdata, r.rdata);
      check("instr_error", {31'b0, instr_error}, {31'b0, r.err});
      check("data_valid_off", {31'b0, data_valid}, 32'd0);
      check("data_error_off", {31'b0, data_error}, 32'd0);
    end else begin
      check("data_valid", {31'b0, data_valid}, 32'd1);
      check("data_rdata", data_rdata, r.rdata);
      check("data_error", {31'b0, data_error}, {31'b0, r.err});
      check("instr_valid_off", {31'b0, instr_valid}, 32'd0);
      check("instr_error_off", {31'b0, instr_error}, 32'd0);
    end
    check("spurious_off", {31'b0, spurious_rsp}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bus_req"}, {31'b0, bus_req}, 32'd0);
    check({tag, "_gnts"}, {30'b0, instr_gnt, data_gnt}, 32'd0);
    check({tag, "_valids"}, {30'b0, instr_valid, data_valid}, 32'd0);
    check({tag, "_errors"}, {30'b0, instr_error, data_error}, 32'd0);
    check({tag, "_instr_rdata"}, instr_rdata, 32'd0);
    check({tag, "_data_rdata"}, data_rdata, 32'd0);
    check({tag, "_spurious"}, {31'b0, spurious_rsp}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state ----------------
    reset_n = 1'b0;
    clear_inputs();
    #3;
    check_all_zero("in_reset");
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check_all_zero("after_reset");

    // ---------------- single-cycle vectors from reset ----------------
    //         ireq iaddr         dreq dwr daddr         dwdata        dbe   gnt val  breq bwr baddr         bwdata        bbe   igt dgt spur
    vecs[0] = '{1'b0, 32'h0,      1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'h0,      1'b0, 1'b1, 32'h44,   32'h55,       4'h6, 1'b0, 1'b0, 1'b0, 1'b1, 32'h44,   32'h55,       4'h6, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 32'h1000,   1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1000, 32'h0,        4'hF, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 32'h1004,   1'b0, 1'b1, 32'h88,   32'h99,       4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1004, 32'h0,        4'hF, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 32'h0,      1'b1, 1'b1, 32'h2000, 32'h1234,     4'hC, 1'b1, 1'b0, 1'b1, 1'b1, 32'h2000, 32'h1234,     4'hC, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 32'h3000,   1'b1, 1'b0, 32'h3100, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 32'h3100, 32'h0,        4'hF, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 32'h0,      1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 32'h0,      1'b0, 1'b0, 32'h7C,   32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h7C,   32'h0,        4'h0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 8; i++) begin
      do_reset();
      instr_req  = vecs[i].ireq;
      instr_addr = vecs[i].iaddr;
      data_req   = vecs[i].dreq;
      data_wr    = vecs[i].dwr;
      data_addr  = vecs[i].daddr;
      data_wdata = vecs[i].dwdata;
      data_be    = vecs[i].dbe;
      bus_gnt    = vecs[i].bgnt;
      bus_valid  = vecs[i].bvalid;
      #1;
      check($sformatf("v%0d_bus_req", i),   {31'b0, bus_req},      {31'b0, vecs[i].e_breq});
      check($sformatf("v%0d_bus_wr", i),    {31'b0, bus_wr},       {31'b0, vecs[i].e_bwr});
      check($sformatf("v%0d_bus_addr", i),  bus_addr,              vecs[i].e_baddr);
      check($sformatf("v%0d_bus_wdata", i), bus_wdata,             vecs[i].e_bwdata);
      check($sformatf("v%0d_bus_be", i),    {28'b0, bus_be},       {28'b0, vecs[i].e_bbe});
      check($sformatf("v%0d_instr_gnt", i), {31'b0, instr_gnt},    {31'b0, vecs[i].e_igt});
      check($sformatf("v%0d_data_gnt", i),  {31'b0, data_gnt},     {31'b0, vecs[i].e_dgt});
      check($sformatf("v%0d_spurious", i),  {31'b0, spurious_rsp}, {31'b0, vecs[i].e_spur});
      check($sformatf("v%0d_valids", i),    {30'b0, instr_valid, data_valid}, 32'd0);
    end

    // ---------------- data read ----------------
    do_reset();
    data_req  = 1'b1;
    data_addr = 32'h100;
    bus_gnt   = 1'b1;
    #1;
    check("rd_bus_addr", bus_addr, 32'h100);
    expect_grant(OWN_DATA, 32'hDEADBEEF, 1'b0);
    tick();
    data_req = 1'b0;
    bus_gnt  = 1'b0;
    respond();
    tick();
    bus_valid = 1'b0;

    // ---------------- contention after reset: data first ----------------
    do_reset();
    instr_req  = 1'b1;
    instr_addr = 32'h200;
    data_req   = 1'b1;
    data_addr  = 32'h300;
    bus_gnt    = 1'b1;
    #1;
    check("cont0_bus_addr", bus_addr, 32'h300);
    expect_grant(OWN_DATA, 32'h11, 1'b0);
    tick();
    data_req = 1'b0;
    #1;
    check("cont1_bus_addr", bus_addr, 32'h200);
    check("cont1_bus_be", {28'b0, bus_be}, 32'hF);
    expect_grant(OWN_INSTR, 32'h22, 1'b0);
    tick();
    instr_req = 1'b0;
    bus_gnt   = 1'b0;
    respond();
    tick();
    respond();
    tick();
    bus_valid = 1'b0;

    // ---------------- lock holds instr while bus stalls ----------------
    do_reset();
    instr_req  = 1'b1;
    instr_addr = 32'h400;
    data_addr  = 32'h500;
    #1;
    check("lock0_bus_req", {31'b0, bus_req}, 32'd1);
    check("lock0_bus_addr", bus_addr, 32'h400);
    tick();
    data_req = 1'b1;
    #1;
    check("lock1_bus_addr", bus_addr, 32'h400);
    check("lock1_data_gnt", {31'b0, data_gnt}, 32'd0);
    tick();
    check("lock2_bus_addr", bus_addr, 32'h400);
    tick();
    bus_gnt = 1'b1;
    #1;
    check("lock3_bus_addr", bus_addr, 32'h400);
    expect_grant(OWN_INSTR, 32'h33, 1'b0);
    tick();
    instr_req = 1'b0;
    #1;
    check("lock4_bus_addr", bus_addr, 32'h500);
    expect_grant(OWN_DATA, 32'h44, 1'b0);
    tick();
    data_req = 1'b0;
    bus_gnt  = 1'b0;
    respond();
    tick();
    respond();
    tick();
    bus_valid = 1'b0;

    // ---------------- full FIFO blocks grants ----------------
    do_reset();
    data_req  = 1'b1;
    data_addr = 32'h600;
    bus_gnt   = 1'b1;
    #1;
    expect_grant(OWN_DATA, 32'hA0, 1'b0);
    tick();
    data_addr = 32'h604;
    #1;
    expect_grant(OWN_DATA, 32'hA1, 1'b0);
    tick();
    data_addr = 32'h608;
    #1;
    check("full_bus_req", {31'b0, bus_req}, 32'd0);
    check("full_data_gnt", {31'b0, data_gnt}, 32'd0);
    tick();
    respond();
    check("full_pop_bus_req", {31'b0, bus_req}, 32'd0);
    check("full_pop_data_gnt", {31'b0, data_gnt}, 32'd0);
    tick();
    bus_valid = 1'b0;
    #1;
    check("full_after_bus_req", {31'b0, bus_req}, 32'd1);
    expect_grant(OWN_DATA, 32'hA2, 1'b0);
    tick();
    data_req = 1'b0;
    bus_gnt  = 1'b0;
    respond();
    tick();
    respond();
    tick();
    bus_valid = 1'b0;

    // ---------------- error response on a data write ----------------
    do_reset();
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_addr  = 32'h700;
    data_wdata = 32'hCAFEF00D;
    data_be    = 4'h3;
    bus_gnt    = 1'b1;
    #1;
    check("wr_bus_wr", {31'b0, bus_wr}, 32'd1);
    check("wr_bus_wdata", bus_wdata, 32'hCAFEF00D);
    check("wr_bus_be", {28'b0, bus_be}, 32'h3);
    expect_grant(OWN_DATA, 32'h0, 1'b1);
    tick();
    clear_inputs();
    respond();
    tick();
    bus_valid = 1'b0;
    bus_error = 1'b0;

    // ---------------- reset mid-flight forgets outstanding ----------------
    do_reset();
    instr_req  = 1'b1;
    instr_addr = 32'h800;
    bus_gnt    = 1'b1;
    #1;
    expect_grant(OWN_INSTR, 32'h55, 1'b0);
    tick();
    clear_inputs();
    #2;
    reset_n = 1'b0;
    sb_q.delete();
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    bus_valid = 1'b1;
    bus_rdata = 32'h55;
    #1;
    check("spur_pulse", {31'b0, spurious_rsp}, 32'd1);
    check("spur_valids", {30'b0, instr_valid, data_valid}, 32'd0);
    check("spur_instr_rdata", instr_rdata, 32'd0);
    tick();
    bus_valid = 1'b0;
    #1;
    check("spur_end", {31'b0, spurious_rsp}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
